// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the I/D memory arbiter
package mem_arbiter_pkg;

    // Access size seen by ram; encoding shared with the ram block.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } ram_size_e;

    // Which requester owned the most recent grant.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and ram signal bundle for mem_arbiter
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_resp_valid;
    logic                  i_resp_ready;
    logic [DATA_WIDTH-1:0] i_resp_data;
    logic                  i_resp_err;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic                  d_req_wr;
    ram_size_e             d_req_size;
    logic                  d_req_unsigned;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic                  d_resp_valid;
    logic                  d_resp_ready;
    logic [DATA_WIDTH-1:0] d_resp_data;
    logic                  d_resp_err;

    logic [ADDR_WIDTH-1:0] ram_addr_o;
    ram_size_e             ram_size_o;
    logic                  ram_unsigned_o;
    logic [DATA_WIDTH-1:0] ram_data_o;
    logic                  ram_wr_enable_o;
    logic [DATA_WIDTH-1:0] ram_data_i;

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_req_addr, i_resp_ready,
        output i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
        input  d_req_valid, d_req_addr, d_req_wr, d_req_size, d_req_unsigned, d_req_wdata, d_resp_ready,
        output d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
        output ram_addr_o, ram_size_o, ram_unsigned_o, ram_data_o, ram_wr_enable_o,
        input  ram_data_i
    );

    // Requesters and ram side.
    modport master (
        output i_req_valid, i_req_addr, i_resp_ready,
        input  i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
        output d_req_valid, d_req_addr, d_req_wr, d_req_size, d_req_unsigned, d_req_wdata, d_resp_ready,
        input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
        input  ram_addr_o, ram_size_o, ram_unsigned_o, ram_data_o, ram_wr_enable_o,
        output ram_data_i
    );

endinterface

// File: rtl/mem_arbiter_resp_slot.sv
// rtl/mem_arbiter_resp_slot.sv - one-entry registered response holder
module resp_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  fill_err,
    input  logic                  drain,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  err
);

    // Capture on fill; a fill on the same edge as a drain leaves the new entry held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            err   <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            data  <= fill_data;
            err   <= fill_err;
        end else if (drain && valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin sharing of ram between fetch and load/store ports
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_port_e             last_grant;
    logic                  i_misaligned;
    logic                  d_misaligned;
    logic                  i_eligible;
    logic                  d_eligible;
    logic                  grant_i;
    logic                  grant_d;
    logic [ADDR_WIDTH-1:0] hold_addr;
    ram_size_e             hold_size;
    logic                  hold_unsigned;
    logic [DATA_WIDTH-1:0] hold_data;

    // Alignment of each pending request; byte accesses are never misaligned.
    always_comb begin
        i_misaligned = (bus.i_req_addr[1:0] != 2'b00);
        d_misaligned = 1'b0;
        case (bus.d_req_size)
            SIZE_HALF: d_misaligned = bus.d_req_addr[0];
            SIZE_WORD: d_misaligned = (bus.d_req_addr[1:0] != 2'b00);
            default:   d_misaligned = 1'b0;
        endcase
    end

    // A port may be granted only if its response has somewhere to go by the next edge.
    always_comb begin
        i_eligible = bus.i_req_valid && (!bus.i_resp_valid || bus.i_resp_ready);
        d_eligible = bus.d_req_valid && (!bus.d_resp_valid || bus.d_resp_ready);
        grant_i    = i_eligible && (!d_eligible || last_grant == PORT_D);
        grant_d    = d_eligible && (!i_eligible || last_grant == PORT_I);
    end

    assign bus.i_req_ready = grant_i;
    assign bus.d_req_ready = grant_d;

    // Steer the granted request onto ram; idle cycles replay the last values so ram never sees X.
    always_comb begin
        bus.ram_addr_o      = hold_addr;
        bus.ram_size_o      = hold_size;
        bus.ram_unsigned_o  = hold_unsigned;
        bus.ram_data_o      = hold_data;
        bus.ram_wr_enable_o = 1'b0;
        if (grant_d) begin
            bus.ram_addr_o      = bus.d_req_addr;
            bus.ram_size_o      = bus.d_req_size;
            bus.ram_unsigned_o  = bus.d_req_unsigned;
            bus.ram_data_o      = bus.d_req_wdata;
            bus.ram_wr_enable_o = bus.d_req_wr && !d_misaligned && !reset;
        end else if (grant_i) begin
            bus.ram_addr_o      = bus.i_req_addr;
            bus.ram_size_o      = SIZE_WORD;
            bus.ram_unsigned_o  = 1'b0;
        end
    end

    // Remember the winner and the values last driven onto ram.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant    <= PORT_I;
            hold_addr     <= '0;
            hold_size     <= SIZE_BYTE;
            hold_unsigned <= 1'b0;
            hold_data     <= '0;
        end else if (grant_i || grant_d) begin
            last_grant    <= grant_d ? PORT_D : PORT_I;
            hold_addr     <= bus.ram_addr_o;
            hold_size     <= bus.ram_size_o;
            hold_unsigned <= bus.ram_unsigned_o;
            hold_data     <= bus.ram_data_o;
        end
    end

    resp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_i_slot (
        .clock     (clock),
        .reset     (reset),
        .fill      (grant_i),
        .fill_data (i_misaligned ? '0 : bus.ram_data_i),
        .fill_err  (i_misaligned),
        .drain     (bus.i_resp_ready),
        .valid     (bus.i_resp_valid),
        .data      (bus.i_resp_data),
        .err       (bus.i_resp_err)
    );

    resp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_d_slot (
        .clock     (clock),
        .reset     (reset),
        .fill      (grant_d),
        .fill_data ((d_misaligned || bus.d_req_wr) ? '0 : bus.ram_data_i),
        .fill_err  (d_misaligned),
        .drain     (bus.d_resp_ready),
        .valid     (bus.d_resp_valid),
        .data      (bus.d_resp_data),
        .err       (bus.d_resp_err)
    );

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single data `ram` between an instruction-fetch requester (I port) and a load/store requester (D port). It is needed once fetch moves from `inst_mem` into the unified `ram` and sits between the core's fetch/LSU logic and `ram`. It performs round-robin grant, valid/ready request handshakes, per-port registered responses with backpressure, and alignment checking.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data width; fixed at 32 for RV32.

Ports (reset reset, asynchronous, active-high; clock clock):
- `clock` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `i_req_valid` in 1: fetch request valid.
- `i_req_ready` out 1: fetch request accepted this cycle.
- `i_req_addr` in ADDR_WIDTH: fetch address. Word-size, read-only.
- `i_resp_valid` out 1: fetch response valid.
- `i_resp_ready` in 1: fetch response consumed.
- `i_resp_data` out DATA_WIDTH: instruction word.
- `i_resp_err` out 1: misaligned fetch.
- `d_req_valid` in 1: load/store request valid.
- `d_req_ready` out 1: load/store request accepted.
- `d_req_addr` in ADDR_WIDTH: byte address.
- `d_req_wr` in 1: 1 = store, 0 = load.
- `d_req_size` in `ram_size_e`: byte, half or word.
- `d_req_unsigned` in 1: zero-extend load.
- `d_req_wdata` in DATA_WIDTH: store data.
- `d_resp_valid` out 1: load/store response valid. Stores also respond.
- `d_resp_ready` in 1: response consumed.
- `d_resp_data` out DATA_WIDTH: load data; 0 for stores and errors.
- `d_resp_err` out 1: misaligned access.
- `ram_addr_o` out ADDR_WIDTH: to `ram.address_i`.
- `ram_size_o` out `ram_size_e`: to `ram.size_i`.
- `ram_unsigned_o` out 1: to `ram.unsigned_i`.
- `ram_data_o` out DATA_WIDTH: to `ram.data_i`.
- `ram_wr_enable_o` out 1: to `ram.wr_enable_i`.
- `ram_data_i` in DATA_WIDTH: from `ram.output_o`. Combinational read.

## Operation
**Eligibility**
- A port is eligible when `req_valid` is high and its response slot is empty, or full with `resp_ready` high in the same cycle.

**Grant policy**
- One eligible port: that port is granted.
- Both ports eligible: the port not granted last time is granted.
- `last_grant` resets to I, so D wins the first tie.
- `req_ready` is high only for the granted port. It is combinational from valid, slot state, `resp_ready` and `last_grant`.

**Request stability**
- Requesters hold address, data and control stable while `req_valid` is high and `req_ready` is low.
- Requesters must not drop `req_valid` before acceptance.

**Misalignment**
- I port: any of `addr[1:0]` nonzero.
- D port, half-word size: `addr[0]` set.
- D port, word size: any of `addr[1:0]` nonzero.
- A misaligned access is still granted and completes with `resp_err` = 1 and `resp_data` = 0.
- `ram_wr_enable_o` stays low for a misaligned access, so no store is committed.

**RAM drive**
- While a port is granted, all `ram_*_o` signals carry that port's request.
- I port grants drive size = word and unsigned = 0.
- When no port is granted: `ram_wr_enable_o` = 0, and address, size and data hold the last driven values. This keeps `ram` inputs free of glitches and X.

**Response slots**
- Each port has one response slot.
- A slot fills on the edge that ends the grant cycle.
- A slot empties on an edge where `resp_valid && resp_ready`.
- Fill and drain on the same edge leaves the slot full with the new data.

**Reset**
- Reset clears both slots: `resp_valid`, `resp_err` and `resp_data` go to 0.
- `last_grant` resets to I.
- An asserted reset suppresses `ram_wr_enable_o`.
- Reset mid-transaction discards pending responses.

## Timing
- Cycle N, `req_valid && req_ready`: `ram` is driven combinationally. A store commits at the edge ending N. Load data is captured into the slot at the same edge.
- Cycle N+1: `resp_valid` = 1. Latency is 1 cycle.
- `resp_valid` stays high until `resp_ready` is sampled high.
- Throughput is one transaction per cycle in total. A port with a draining consumer can be granted every cycle when it is the only requester.
- Under contention each port gets at most every other cycle.
- A port whose slot is full and not draining is stalled. The other port then gets every cycle; this is the no-starvation rule.
- No combinational path from `ram_data_i` to any output.

## Structure
- Shared package `types`:
  - add `arb_port_e` {`PORT_I`, `PORT_D`} for `last_grant`.
  - reuse the existing `ram_size_e`.
- Sub-module `resp_slot`, instantiated twice. It holds one data+err entry with `fill`, `drain`, `valid` and the same-edge fill/drain rule.
- Alignment check and grant logic are combinational in the top level.

## Test plan
- **Single fetch:** I only, addr 0x10, ram word 0x00500093 → `i_req_ready` = 1 in the same cycle, `i_resp_valid` = 1 the next cycle with data 0x00500093, `i_resp_err` = 0.
- **Contention after reset:** both valid at cycle 0 → D granted at cycle 0, I at cycle 1, D at cycle 2. Grants alternate while both stay valid.
- **Backpressure:** `d_resp_ready` = 0 with the D slot full, both requesting → I granted every cycle, D stalled. Raising `d_resp_ready` → D granted in that same cycle.
- **Store then load:** store word 0xDEADBEEF to 0x40, then load byte unsigned at 0x43 → store response has data 0. Load response 0x000000DE arrives the cycle after the load grant.
- **Misaligned:** store half to 0x41 → `d_resp_err` = 1, `ram_wr_enable_o` never high, and a later word load of 0x40 returns its old contents. Fetch at 0x2 → `i_resp_err` = 1.
- **Reset mid-operation:** assert `reset` with both slots full → `resp_valid` drops immediately and asynchronously. After release, a tie grants D first.
